// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus fabric.
//   DRW_*            : encodings of the CPU data read/write command
//   SEL_W            : width of the module-select field in an address
//   ERR_DATA_DEFAULT : word returned on timed-out or unmapped accesses
//   rr_e             : which port wins a single-ported module conflict
package bus_pkg;

  localparam logic [1:0] DRW_NOP   = 2'b00;
  localparam logic [1:0] DRW_WRITE = 2'b01;
  localparam logic [1:0] DRW_READ  = 2'b10;

  localparam int SEL_W = 8;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic {
    RR_I = 1'b0,
    RR_D = 1'b1
  } rr_e;

endpackage

// File: rtl/bus_decode.sv
// Address decoder for one CPU port.
//   addr     : CPU address (word aligned)
//   sel      : module-select field addr[SEL_LSB+7:SEL_LSB]
//   eff_addr : address with the select field zeroed, as seen by the module
//   mapped   : select value names an existing module slot
module bus_decode
  import bus_pkg::*;
#(
  parameter int NUM_MODS = 12,
  parameter int SEL_LSB  = 24
) (
  input  logic [31:0]      addr,
  output logic [SEL_W-1:0] sel,
  output logic [31:0]      eff_addr,
  output logic             mapped
);

  localparam logic [31:0] SEL_MASK = 32'h0000_00FF << SEL_LSB;

  assign sel      = addr[SEL_LSB +: SEL_W];
  assign eff_addr = addr & ~SEL_MASK;
  assign mapped   = int'(sel) < NUM_MODS;

endmodule

// File: rtl/bus_fabric.sv
// CPU bus fabric: decodes the instruction and data ports onto NUM_MODS
// module slots, arbitrates single-ported modules round-robin, muxes read
// data back and runs a stall watchdog that reports bus errors.
//   clk, rst            : clock, asynchronous active-low reset
//   cpu_iaddr/cpu_daddr : instruction / data address from the CPU
//   cpu_drw             : data command (nop / write / read)
//   cpu_bus_data        : CPU write data
//   bus_cpu_inst/_data  : instruction / read data to the CPU
//   cpu_stall           : freezes the CPU pipeline
//   bus_err             : one-cycle pulse on timeout or unmapped access
//   bus_err_addr        : address of the most recent error
//   mod_ie/mod_de       : one-hot instruction / data enables
//   mod_iaddr/mod_daddr : addresses with the select field zeroed
//   mod_drw, mod_wdata  : gated command and write data to the modules
//   mod_inst/mod_data   : packed per-slot instruction / read data
//   mod_rdy             : per-slot access-complete strobe
module bus_fabric
  import bus_pkg::*;
#(
  parameter int                  NUM_MODS    = 12,
  parameter int                  SEL_LSB     = 24,
  parameter logic [NUM_MODS-1:0] SINGLE_PORT = '0,
  parameter int                  TIMEOUT     = 255,
  parameter logic [31:0]         ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              cpu_iaddr,
  input  logic [31:0]              cpu_daddr,
  input  logic [1:0]               cpu_drw,
  input  logic [31:0]              cpu_bus_data,
  output logic [31:0]              bus_cpu_inst,
  output logic [31:0]              bus_cpu_data,
  output logic                     cpu_stall,
  output logic                     bus_err,
  output logic [31:0]              bus_err_addr,
  output logic [NUM_MODS-1:0]      mod_ie,
  output logic [NUM_MODS-1:0]      mod_de,
  output logic [31:0]              mod_iaddr,
  output logic [31:0]              mod_daddr,
  output logic [1:0]               mod_drw,
  output logic [31:0]              mod_wdata,
  input  logic [NUM_MODS*32-1:0]   mod_inst,
  input  logic [NUM_MODS*32-1:0]   mod_data,
  input  logic [NUM_MODS-1:0]      mod_rdy
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [SEL_W-1:0] isel, dsel;
  logic             i_map, d_map;
  logic [31:0]      inst_sel, data_sel;
  logic             i_rdy, d_rdy, sp_hit;

  logic             d_active, conflict;
  logic             i_req, d_req, i_grant, d_grant, i_ok, d_ok;
  logic             i_pending, d_pending, raw_stall, expire;
  logic             err_now, d_err;
  logic [31:0]      err_addr_now;

  rr_e              rr_ptr;
  logic [CNT_W-1:0] stall_cnt;
  logic [31:0]      err_addr_q;
  // A port that completes while the other port is still stalling is marked
  // done, so it is not re-issued and its word is replayed from a hold reg.
  logic             i_done, d_done;
  logic [31:0]      inst_q, data_q;

  bus_decode #(.NUM_MODS(NUM_MODS), .SEL_LSB(SEL_LSB)) u_idec (
    .addr     (cpu_iaddr),
    .sel      (isel),
    .eff_addr (mod_iaddr),
    .mapped   (i_map)
  );

  bus_decode #(.NUM_MODS(NUM_MODS), .SEL_LSB(SEL_LSB)) u_ddec (
    .addr     (cpu_daddr),
    .sel      (dsel),
    .eff_addr (mod_daddr),
    .mapped   (d_map)
  );

  // Per-slot mux of read data, ready and the single-port flag.
  // NOTE: every variable written here gets a default first, otherwise an
  // unmatched select would leave it holding its old value (a latch).
  always_comb begin
    inst_sel = '0;
    data_sel = '0;
    i_rdy    = 1'b0;
    d_rdy    = 1'b0;
    sp_hit   = 1'b0;
    for (int n = 0; n < NUM_MODS; n++) begin
      if (isel == SEL_W'(n)) begin
        inst_sel = mod_inst[n*32 +: 32];
        i_rdy    = mod_rdy[n];
        sp_hit   = SINGLE_PORT[n];
      end
      if (dsel == SEL_W'(n)) begin
        data_sel = mod_data[n*32 +: 32];
        d_rdy    = mod_rdy[n];
      end
    end
  end

  // Arbitration. Requests are gated by rst so enables drop asynchronously.
  assign d_active = (cpu_drw != DRW_NOP);
  assign conflict = rst && i_map && d_active && d_map && (isel == dsel) && sp_hit;
  assign i_req    = rst && i_map && !i_done;
  assign d_req    = rst && d_active && d_map && !d_done;
  assign i_grant  = i_req && (!conflict || rr_ptr == RR_I);
  assign d_grant  = d_req && (!conflict || rr_ptr == RR_D);
  assign i_ok     = i_grant && i_rdy;
  assign d_ok     = d_grant && d_rdy;

  // Stall and watchdog. Expiry only happens while something is still
  // pending, so rdy arriving on the expiry cycle completes normally.
  assign i_pending = i_req && !i_ok;
  assign d_pending = d_req && !d_ok;
  assign raw_stall = i_pending || d_pending;
  assign expire    = raw_stall && (stall_cnt == CNT_MAX);
  assign cpu_stall = raw_stall && !expire;

  // Error reporting: unmapped accesses and expiries share one pulse; the
  // data address wins whenever the data port is involved.
  assign err_now      = (rst && (!i_map || (d_active && !d_map))) || expire;
  assign d_err        = (d_active && !d_map) || (expire && d_pending);
  assign err_addr_now = d_err ? cpu_daddr : cpu_iaddr;
  assign bus_err      = err_now;
  assign bus_err_addr = err_now ? err_addr_now : err_addr_q;

  always_comb begin
    mod_ie = '0;
    mod_de = '0;
    for (int n = 0; n < NUM_MODS; n++) begin
      if (i_grant && isel == SEL_W'(n)) mod_ie[n] = 1'b1;
      if (d_grant && dsel == SEL_W'(n)) mod_de[n] = 1'b1;
    end
  end

  assign mod_drw   = d_grant ? cpu_drw : DRW_NOP;
  assign mod_wdata = cpu_bus_data;

  always_comb begin
    if (!i_map)                   bus_cpu_inst = ERR_DATA;
    else if (i_done)              bus_cpu_inst = inst_q;
    else if (expire && i_pending) bus_cpu_inst = ERR_DATA;
    else if (i_grant)             bus_cpu_inst = inst_sel;
    else                          bus_cpu_inst = '0;
  end

  always_comb begin
    if (!d_active)                bus_cpu_data = '0;
    else if (!d_map)              bus_cpu_data = ERR_DATA;
    else if (d_done)              bus_cpu_data = data_q;
    else if (expire && d_pending) bus_cpu_data = ERR_DATA;
    else if (d_grant)             bus_cpu_data = data_sel;
    else                          bus_cpu_data = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= RR_I;
      stall_cnt  <= '0;
      err_addr_q <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
    end else begin
      if (conflict && (i_ok || d_ok))
        rr_ptr <= (rr_ptr == RR_I) ? RR_D : RR_I;
      stall_cnt <= cpu_stall ? stall_cnt + CNT_W'(1) : '0;
      if (err_now)
        err_addr_q <= err_addr_now;
      i_done <= cpu_stall && (i_done || i_ok);
      d_done <= cpu_stall && (d_done || d_ok);
    end
  end

  // NOTE: the hold registers carry data only and are qualified by the done
  // flags, so they need no reset.
  always_ff @(posedge clk) begin
    if (cpu_stall && i_ok) inst_q <= inst_sel;
    if (cpu_stall && d_ok) data_q <= data_sel;
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: the driver applies one vector per cycle
// and queues its hand-computed expectation; the monitor pops and compares
// on the falling edge.
module tb_bus_fabric;
  import bus_pkg::*;

  localparam int NM = 12;

  localparam int EN  = 1;   // mod_ie / mod_de
  localparam int STL = 2;   // cpu_stall
  localparam int ERR = 4;   // bus_err
  localparam int EAD = 8;   // bus_err_addr
  localparam int INS = 16;  // bus_cpu_inst
  localparam int DAT = 32;  // bus_cpu_data
  localparam int MAD = 64;  // mod_daddr / mod_drw
  localparam int ALL = 127;

  localparam logic [31:0] ED = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       cpu_iaddr = '0, cpu_daddr = '0, cpu_bus_data = 32'h5A5A_0001;
  logic [1:0]        cpu_drw = 2'b00;
  logic [31:0]       bus_cpu_inst, bus_cpu_data, bus_err_addr;
  logic              cpu_stall, bus_err;
  logic [NM-1:0]     mod_ie, mod_de, mod_rdy = '1;
  logic [31:0]       mod_iaddr, mod_daddr, mod_wdata;
  logic [1:0]        mod_drw;
  logic [NM*32-1:0]  mod_inst, mod_data;

  always #5 clk = ~clk;

  bus_fabric #(
    .NUM_MODS    (NM),
    .SEL_LSB     (24),
    .SINGLE_PORT (12'h002),
    .TIMEOUT     (8),
    .ERR_DATA    (32'hDEADBEEF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_iaddr    (cpu_iaddr),
    .cpu_daddr    (cpu_daddr),
    .cpu_drw      (cpu_drw),
    .cpu_bus_data (cpu_bus_data),
    .bus_cpu_inst (bus_cpu_inst),
    .bus_cpu_data (bus_cpu_data),
    .cpu_stall    (cpu_stall),
    .bus_err      (bus_err),
    .bus_err_addr (bus_err_addr),
    .mod_ie       (mod_ie),
    .mod_de       (mod_de),
    .mod_iaddr    (mod_iaddr),
    .mod_daddr    (mod_daddr),
    .mod_drw      (mod_drw),
    .mod_wdata    (mod_wdata),
    .mod_inst     (mod_inst),
    .mod_data     (mod_data),
    .mod_rdy      (mod_rdy)
  );

  typedef struct {
    string       nm;
    int          m;
    logic [11:0] ie, de;
    logic        stl, err;
    logic [31:0] ead, ins, dat, mad;
    logic [1:0]  mdrw;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] iw(input int n);
    return 32'h1000_0000 + 32'(n);
  endfunction

  function automatic logic [31:0] dw(input int n);
    return 32'hD000_0000 + 32'(n);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, queue its expectation, advance one clock.
  task automatic cyc(input string nm, input logic [31:0] ia, input logic [31:0] da,
                     input logic [1:0] drw, input logic [11:0] rdy, input int m,
                     input logic [11:0] ie, input logic [11:0] de,
                     input logic stl, input logic err, input logic [31:0] ead,
                     input logic [31:0] ins, input logic [31:0] dat,
                     input logic [31:0] mad, input logic [1:0] mdrw);
    exp_t e;
    cpu_iaddr = ia;
    cpu_daddr = da;
    cpu_drw   = drw;
    mod_rdy   = rdy;
    e.nm = nm; e.m = m; e.ie = ie; e.de = de; e.stl = stl; e.err = err;
    e.ead = ead; e.ins = ins; e.dat = dat; e.mad = mad; e.mdrw = mdrw;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever expectation is queued for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if ((e.m & EN) != 0) begin
          check({e.nm, "/ie"}, 32'(mod_ie), 32'(e.ie));
          check({e.nm, "/de"}, 32'(mod_de), 32'(e.de));
        end
        if ((e.m & STL) != 0) check({e.nm, "/stall"}, 32'(cpu_stall), 32'(e.stl));
        if ((e.m & ERR) != 0) check({e.nm, "/bus_err"}, 32'(bus_err), 32'(e.err));
        if ((e.m & EAD) != 0) check({e.nm, "/err_addr"}, bus_err_addr, e.ead);
        if ((e.m & INS) != 0) check({e.nm, "/inst"}, bus_cpu_inst, e.ins);
        if ((e.m & DAT) != 0) check({e.nm, "/data"}, bus_cpu_data, e.dat);
        if ((e.m & MAD) != 0) begin
          check({e.nm, "/mod_daddr"}, mod_daddr, e.mad);
          check({e.nm, "/mod_drw"}, 32'(mod_drw), 32'(e.mdrw));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int n = 0; n < NM; n++) begin
      mod_inst[n*32 +: 32] = iw(n);
      mod_data[n*32 +: 32] = dw(n);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Reset: enables gated, no stall, no error, error address cleared.
    cyc("reset", 32'h0100_0010, 32'h0200_0004, DRW_READ, 12'hFFF, EN|STL|ERR|EAD,
        12'h000, 12'h000, 0, 0, 32'h0, 0, 0, 0, 0);
    rst = 1'b1;

    // Decode and data path.
    cyc("decode_rd", 32'h0100_0010, 32'h0200_0004, DRW_READ, 12'hFFF, ALL,
        12'h002, 12'h004, 0, 0, 32'h0, iw(1), dw(2), 32'h0000_0004, DRW_READ);
    cyc("decode_wr", 32'h0000_0000, 32'h0A00_0100, DRW_WRITE, 12'hFFF, ALL,
        12'h001, 12'h400, 0, 0, 32'h0, iw(0), dw(10), 32'h0000_0100, DRW_WRITE);
    cyc("decode_idle", 32'h0200_0008, 32'h0300_0000, DRW_NOP, 12'hFFF, ALL,
        12'h004, 12'h000, 0, 0, 32'h0, iw(2), 32'h0, 32'h0, DRW_NOP);
    cyc("dual_port_same", 32'h0200_0000, 32'h0200_0010, DRW_READ, 12'hFFF, EN|STL|INS|DAT,
        12'h004, 12'h004, 0, 0, 0, iw(2), dw(2), 0, 0);
    cyc("sel_max", 32'h0000_0000, 32'h0B00_0000, DRW_READ, 12'hFFF, EN|STL|ERR|DAT,
        12'h001, 12'h800, 0, 0, 0, 0, dw(11), 0, 0);

    // Single-port conflict on module 1: I first, then D, then I again.
    cyc("conflict_c0", 32'h0100_0020, 32'h0100_0040, DRW_READ, 12'hFFF, EN|STL|INS|MAD,
        12'h002, 12'h000, 1, 0, 0, iw(1), 0, 32'h0000_0040, DRW_NOP);
    cyc("conflict_c1", 32'h0100_0020, 32'h0100_0040, DRW_READ, 12'hFFF, EN|STL|INS|DAT|MAD,
        12'h000, 12'h002, 0, 0, 0, iw(1), dw(1), 32'h0000_0040, DRW_READ);
    cyc("conflict_c2", 32'h0100_0020, 32'h0100_0040, DRW_READ, 12'hFFF, EN|STL,
        12'h002, 12'h000, 1, 0, 0, 0, 0, 0, 0);
    cyc("conflict_c3", 32'h0100_0020, 32'h0100_0040, DRW_READ, 12'hFFF, EN|STL|DAT,
        12'h000, 12'h002, 0, 0, 0, 0, dw(1), 0, 0);

    // Module 3 slow for 4 cycles.
    cyc("slow_c0", 32'h0, 32'h0300_0010, DRW_READ, 12'hFF7, EN|STL|INS,
        12'h001, 12'h008, 1, 0, 0, iw(0), 0, 0, 0);
    for (int k = 1; k < 4; k++)
      cyc("slow_wait", 32'h0, 32'h0300_0010, DRW_READ, 12'hFF7, EN|STL|INS,
          12'h000, 12'h008, 1, 0, 0, iw(0), 0, 0, 0);
    cyc("slow_done", 32'h0, 32'h0300_0010, DRW_READ, 12'hFFF, EN|STL|INS|DAT,
        12'h000, 12'h008, 0, 0, 0, iw(0), dw(3), 0, 0);

    // Module 5 never ready: 8 stall cycles, expiry on the 9th.
    cyc("wdog_c0", 32'h0, 32'h0500_0020, DRW_READ, 12'hFDF, EN|STL|ERR,
        12'h001, 12'h020, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 8; k++)
      cyc("wdog_wait", 32'h0, 32'h0500_0020, DRW_READ, 12'hFDF, EN|STL|ERR,
          12'h000, 12'h020, 1, 0, 0, 0, 0, 0, 0);
    cyc("wdog_expire", 32'h0, 32'h0500_0020, DRW_READ, 12'hFDF, EN|STL|ERR|EAD|INS|DAT,
        12'h000, 12'h020, 0, 1, 32'h0500_0020, iw(0), ED, 0, 0);
    cyc("wdog_after", 32'h0100_0000, 32'h0, DRW_NOP, 12'hFFF, STL|ERR|EAD,
        0, 0, 0, 0, 32'h0500_0020, 0, 0, 0, 0);

    // Unmapped accesses.
    cyc("unmapped_d", 32'h0100_0000, 32'h0F00_0000, DRW_READ, 12'hFFF, EN|STL|ERR|EAD|DAT|MAD,
        12'h002, 12'h000, 0, 1, 32'h0F00_0000, 0, ED, 32'h0, DRW_NOP);
    cyc("unmapped_d_edge", 32'h0100_0000, 32'h0C00_0000, DRW_WRITE, 12'hFFF, EN|STL|ERR|EAD|DAT,
        12'h002, 12'h000, 0, 1, 32'h0C00_0000, 0, ED, 0, 0);
    cyc("unmapped_i", 32'h2000_0000, 32'h0, DRW_NOP, 12'hFFF, EN|STL|ERR|EAD|INS|DAT,
        12'h000, 12'h000, 0, 1, 32'h2000_0000, ED, 32'h0, 0, 0);
    cyc("unmapped_both", 32'h2000_0000, 32'hFF00_0000, DRW_WRITE, 12'hFFF, EN|STL|ERR|EAD|INS|DAT,
        12'h000, 12'h000, 0, 1, 32'hFF00_0000, ED, ED, 0, 0);
    cyc("err_idle", 32'h0, 32'h0, DRW_NOP, 12'hFFF, ERR|EAD,
        0, 0, 0, 0, 32'hFF00_0000, 0, 0, 0, 0);

    // Reset in the middle of a stall with rr_ptr pointing at D.
    cyc("rst_c0", 32'h0100_0000, 32'h0100_0004, DRW_READ, 12'hFFF, EN|STL,
        12'h002, 12'h000, 1, 0, 0, 0, 0, 0, 0);
    cyc("rst_c1", 32'h0100_0000, 32'h0100_0004, DRW_READ, 12'hFFD, EN|STL,
        12'h000, 12'h002, 1, 0, 0, 0, 0, 0, 0);
    cyc("rst_c2", 32'h0100_0000, 32'h0100_0004, DRW_READ, 12'hFFD, EN|STL,
        12'h000, 12'h002, 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("rst_async", 32'h0100_0000, 32'h0100_0004, DRW_READ, 12'hFFD, EN|STL|ERR|EAD,
        12'h000, 12'h000, 0, 0, 32'h0, 0, 0, 0, 0);
    cyc("rst_hold", 32'h0100_0000, 32'h0100_0004, DRW_READ, 12'hFFD, EN|STL|ERR|EAD,
        12'h000, 12'h000, 0, 0, 32'h0, 0, 0, 0, 0);
    rst = 1'b1;

    // Counter restarted from zero: full 8 stall cycles before expiry.
    for (int k = 0; k < 8; k++)
      cyc("post_rst_wdog", 32'h0, 32'h0500_0000, DRW_READ, 12'hFDF, STL|ERR,
          0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("post_rst_expire", 32'h0, 32'h0500_0000, DRW_READ, 12'hFDF, STL|ERR|EAD|DAT,
        0, 0, 0, 1, 32'h0500_0000, 0, ED, 0, 0);

    // rr_ptr back at I: I wins the first conflict cycle.
    cyc("post_rst_rr_c0", 32'h0100_0000, 32'h0100_0008, DRW_READ, 12'hFFF, EN|STL,
        12'h002, 12'h000, 1, 0, 0, 0, 0, 0, 0);
    cyc("post_rst_rr_c1", 32'h0100_0000, 32'h0100_0008, DRW_READ, 12'hFFF, EN|STL|DAT,
        12'h000, 12'h002, 0, 0, 0, 0, dw(1), 0, 0);

    cpu_drw = DRW_NOP;
    repeat (2) @(posedge clk);
    check("drain", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised successor to the fixed 12-slot CPU bus arbiter. Decodes instruction and data addresses to NUM_MODS module slots and muxes the read data back to the CPU.
- Adds three things the fixed arbiter lacks: a per-module ready handshake, round-robin arbitration when both ports hit the same single-ported module, and a stall watchdog with bus-error reporting.
- Sits between the CPU and all memory-mapped modules.

Parameters:
- NUM_MODS, 12: number of module slots; legal range 1..256.
- SEL_LSB, 24: low bit of the 8-bit module-select field; select = addr[SEL_LSB+7:SEL_LSB].
- SINGLE_PORT, 12'h000: NUM_MODS-bit mask; bit n=1 means module n cannot serve I and D in the same cycle.
- TIMEOUT, 255: consecutive stall cycles before the watchdog fires; width is $clog2(TIMEOUT+1).
- ERR_DATA, 32'hDEADBEEF: word returned to the CPU on a timed-out or unmapped access.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- cpu_iaddr  input  32  instruction address, word aligned
- cpu_daddr  input  32  data address, word aligned
- cpu_drw  input  2  00 nop, 01 write, 10 read
- cpu_bus_data  input  32  write data from the CPU
- bus_cpu_inst  output  32  instruction to the CPU
- bus_cpu_data  output  32  read data to the CPU
- cpu_stall  output  1  freezes the CPU pipeline
- bus_err  output  1  one-cycle pulse on timeout or unmapped access
- bus_err_addr  output  32  address of the most recent error
- mod_ie  output  NUM_MODS  one-hot instruction enable
- mod_de  output  NUM_MODS  one-hot data enable
- mod_iaddr  output  32  effective instruction address (select field zeroed)
- mod_daddr  output  32  effective data address (select field zeroed)
- mod_drw  output  2  cpu_drw gated by the data grant; 00 when data is not granted
- mod_wdata  output  32  cpu_bus_data passthrough
- mod_inst  input  NUM_MODS*32  packed instruction words, slot n at [32n+31:32n]
- mod_data  input  NUM_MODS*32  packed read data, same packing
- mod_rdy  input  NUM_MODS  module n has completed its access this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - rr_ptr=0, stall_cnt=0, bus_err=0, bus_err_addr=0.
  - Combinational outputs follow their rules with grants cleared: mod_ie=0, mod_de=0, cpu_stall=0.
- Decode:
  - isel/dsel = select fields of cpu_iaddr/cpu_daddr.
  - A select value >= NUM_MODS is unmapped: no enable is asserted, ERR_DATA is returned combinationally, and there is no stall.
- Activity:
  - The I port is active every cycle.
  - The D port is active only when cpu_drw != 00.
- Conflict: isel==dsel, D active, and SINGLE_PORT[isel]=1.
  - No conflict: both ports are granted.
  - Conflict: only the port named by rr_ptr is granted (0=I, 1=D); the other port's enable is 0 and it stalls.
  - rr_ptr toggles on the cycle the granted conflicting access sees its module's rdy=1, so a conflict resolves in at least 2 cycles.
- Data path:
  - bus_cpu_inst = mod_inst[isel] when I is granted.
  - bus_cpu_data = mod_data[dsel] when D is granted and D is active; 0 when D is idle.
  - Latency is 0 cycles: combinational, same cycle as rdy.
- Stall:
  - cpu_stall=1 when any active port is ungranted, or is granted to a mapped module with rdy=0.
  - Stall is never asserted for unmapped accesses.
- Watchdog:
  - stall_cnt increments each cycle cpu_stall=1 and clears when cpu_stall=0.
  - When stall_cnt==TIMEOUT:
    - cpu_stall is forced to 0 for that cycle.
    - Each stalled port receives ERR_DATA.
    - bus_err pulses 1.
    - bus_err_addr latches the daddr if D was stalled, otherwise the iaddr.
    - stall_cnt clears.
  - Writes that time out are dropped silently.
- Unmapped access: bus_err pulses in the same cycle and bus_err_addr latches the offending address (D has priority if both ports are unmapped).
- Simultaneous events:
  - A watchdog expiry and an unmapped access in the same cycle produce one pulse; bus_err_addr holds the D address.
  - rdy arriving in the same cycle the watchdog expires counts as normal completion: no error, and the counter clears.
- Reset mid-stall aborts the transaction; enables drop immediately.

Decomposition:
- Shared package bus_pkg:
  - DRW_NOP/DRW_WRITE/DRW_READ encodings
  - SEL_W=8 constant
  - ERR_DATA default
- One sub-module, bus_decode: select extraction, effective address and mapped flag. Instantiated once per port.
- Arbitration, stall and watchdog logic stay in bus_fabric.

Test Plan:
- Default parameters, iaddr=0x01000010, daddr=0x02000004, drw=10, mod_rdy=all 1 → mod_ie=0x002, mod_de=0x004, mod_daddr=0x00000004, no stall.
- SINGLE_PORT=12'h002, both ports select module 1, rdy=1 → cycle 0: I granted and D stalls; cycle 1: D granted and stall deasserts; rr_ptr ends at 0.
- Module 3 holds rdy=0 for 4 cycles on a data read → cpu_stall=1 for exactly 4 cycles; read data is visible on the 5th cycle.
- TIMEOUT=8, module 5 never asserts rdy → cpu_stall is high for 8 cycles; cycle 9: bus_cpu_data=0xDEADBEEF, bus_err=1 and bus_err_addr=daddr.
- daddr=0x0F000000 with NUM_MODS=12 → mod_de=0, bus_cpu_data=0xDEADBEEF, bus_err pulse, cpu_stall=0.
- Assert rst low during a 3-cycle stall → all enables and cpu_stall drop asynchronously; after release stall_cnt=0 and rr_ptr=0.
